// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC register and the IF/ID pipeline register.
// Ports: clk/rst, StallF/StallD/FlushD/PCSrcE/PCTargetE hazard+redirect inputs,
//        InstrF from imem, PCF to imem, InstrD/PCD/PCPlus4D/ValidD to decode,
//        MisalignF sticky misaligned-redirect flag.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignF
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4d_q, pcp4d_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect beats stall so a taken branch is never dropped.
    always_comb begin
        pc_d       = pc_plus4;
        misalign_d = misalign_q;
        if (PCSrcE) begin
            pc_d = {PCTargetE[31:2], 2'b00};
            if (PCTargetE[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (StallF) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4d_d = 32'd0;
            valid_d = 1'b0;
        end else if (!StallD) begin
            instr_d = InstrF;
            pcd_d   = pc_q;
            pcp4d_d = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pcd_q      <= 32'd0;
            pcp4d_q    <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pcp4d_q    <= pcp4d_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4d_q;
    assign ValidD    = valid_q;
    assign MisalignF = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational word-indexed imem model.
// Expected values are hand-computed constants.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignF;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .MisalignF (MisalignF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k lives at byte address 4k.
    always_comb InstrF = 32'hA000_0000 | (PCF >> 2);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check("rst_pcf", PCF, 32'h0);
        check("rst_instr", InstrD, 32'h13);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pcp4", PCPlus4D, 32'h0);
        check("rst_valid", {31'd0, ValidD}, 32'h0);
        check("rst_mis", {31'd0, MisalignF}, 32'h0);

        // Inputs ignored while in reset.
        PCSrcE = 1'b1;
        PCTargetE = 32'h42;
        tick();
        check("rst_hold_pcf", PCF, 32'h0);
        check("rst_hold_mis", {31'd0, MisalignF}, 32'h0);
        idle();
        rst = 1'b0;

        // Sequential fetch.
        tick();
        check("seq1_pcf", PCF, 32'h4);
        check("seq1_instr", InstrD, 32'hA000_0000);
        check("seq1_pcd", PCD, 32'h0);
        check("seq1_pcp4", PCPlus4D, 32'h4);
        check("seq1_valid", {31'd0, ValidD}, 32'h1);
        tick();
        check("seq2_pcf", PCF, 32'h8);
        check("seq2_instr", InstrD, 32'hA000_0001);
        check("seq2_pcd", PCD, 32'h4);
        tick();
        check("seq3_pcf", PCF, 32'hC);
        check("seq3_pcd", PCD, 32'h8);
        tick();
        check("seq4_pcf", PCF, 32'h10);
        check("seq4_pcd", PCD, 32'hC);
        check("seq4_instr", InstrD, 32'hA000_0003);

        // Full stall for two cycles.
        StallF = 1'b1;
        StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_pcf", PCF, 32'h10);
            check("stall_pcd", PCD, 32'hC);
            check("stall_instr", InstrD, 32'hA000_0003);
        end
        idle();
        tick();
        check("rel_pcf", PCF, 32'h14);
        check("rel_pcd", PCD, 32'h10);
        check("rel_instr", InstrD, 32'hA000_0004);

        // StallF only: same pair captured repeatedly.
        StallF = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sf_pcf", PCF, 32'h14);
            check("sf_pcd", PCD, 32'h14);
            check("sf_pcp4", PCPlus4D, 32'h18);
            check("sf_instr", InstrD, 32'hA000_0005);
            check("sf_valid", {31'd0, ValidD}, 32'h1);
        end
        idle();

        // Redirect + flush with both stalls asserted.
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
        FlushD = 1'b1;
        StallF = 1'b1;
        StallD = 1'b1;
        tick();
        check("rd_pcf", PCF, 32'h100);
        check("rd_instr", InstrD, 32'h13);
        check("rd_valid", {31'd0, ValidD}, 32'h0);
        check("rd_pcd", PCD, 32'h0);
        check("rd_pcp4", PCPlus4D, 32'h0);
        idle();
        tick();
        check("rd2_instr", InstrD, 32'hA000_0040);
        check("rd2_pcd", PCD, 32'h100);
        check("rd2_pcp4", PCPlus4D, 32'h104);
        check("rd2_pcf", PCF, 32'h104);

        // Misaligned redirect, then sticky through an aligned one.
        PCSrcE = 1'b1;
        PCTargetE = 32'h206;
        tick();
        check("mis_pcf", PCF, 32'h204);
        check("mis_flag", {31'd0, MisalignF}, 32'h1);
        PCTargetE = 32'h300;
        tick();
        check("mis2_pcf", PCF, 32'h300);
        check("mis2_flag", {31'd0, MisalignF}, 32'h1);
        idle();
        tick();
        check("mis3_flag", {31'd0, MisalignF}, 32'h1);

        // Wrap at top of address space.
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        tick();
        check("wrap0_pcf", PCF, 32'hFFFF_FFFC);
        idle();
        tick();
        check("wrap_pcf", PCF, 32'h0);
        check("wrap_pcd", PCD, 32'hFFFF_FFFC);
        check("wrap_pcp4", PCPlus4D, 32'h0);
        check("wrap_instr", InstrD, 32'hBFFF_FFFF);
        tick();
        check("post_wrap_pcf", PCF, 32'h4);

        // Async reset mid-stall, between edges.
        StallF = 1'b1;
        StallD = 1'b1;
        tick();
        check("pre_rst_pcf", PCF, 32'h4);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pcf", PCF, 32'h0);
        check("arst_instr", InstrD, 32'h13);
        check("arst_pcd", PCD, 32'h0);
        check("arst_pcp4", PCPlus4D, 32'h0);
        check("arst_valid", {31'd0, ValidD}, 32'h0);
        check("arst_mis", {31'd0, MisalignF}, 32'h0);
        #1;
        rst = 1'b0;
        idle();
        tick();
        check("post_rst_pcf", PCF, 32'h4);
        check("post_rst_pcd", PCD, 32'h0);
        check("post_rst_valid", {31'd0, ValidD}, 32'h1);
        check("post_rst_instr", InstrD, 32'hA000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
